// File: rtl/nn_cpu_pipe.sv
// Three-stage (IF / ID / EX-WB) neural-network processor core with EX->ID forwarding,
// fused multiply-accumulate, ReLU, HALT and a pipeline-wide stall.
module nn_cpu_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int REG_BITS = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic [31:0]       CLK_cycle
);

    localparam int NREGS = 1 << REG_BITS;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_MAC  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_RELU = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic [ADDR_W-1:0]   pc;
    logic [31:0]         ifidInstr;
    logic                haltPending;
    logic [DATA_W-1:0]   regs [NREGS];

    logic [3:0]          idOp;
    logic [REG_BITS-1:0] idRegA, idRegB, idRegC, idDest;
    logic [DATA_W-1:0]   idValA, idValB, idValC, idImm;
    logic                idWe;
    logic                haltFetch;

    logic [3:0]          exOp;
    logic                exWe;
    logic [REG_BITS-1:0] exDest;
    logic [DATA_W-1:0]   exValA, exValB, exValC, exImm;
    logic [DATA_W-1:0]   exSum, exResult;

    assign imem_addr = pc;

    assign idOp   = ifidInstr[31:28];
    assign idRegA = ifidInstr[22 +: REG_BITS];
    assign idRegB = ifidInstr[16 +: REG_BITS];
    assign idRegC = ifidInstr[10 +: REG_BITS];
    assign idImm  = DATA_W'($signed(ifidInstr[15:0]));

    // Register 0 reads as zero; exWe is never set for register 0, so it is never forwarded.
    assign idValA = (idRegA == '0) ? '0 : (exWe && exDest == idRegA) ? exResult : regs[idRegA];
    assign idValB = (idRegB == '0) ? '0 : (exWe && exDest == idRegB) ? exResult : regs[idRegB];
    assign idValC = (idRegC == '0) ? '0 : (exWe && exDest == idRegC) ? exResult : regs[idRegC];

    // Once HALT reaches decode, fetch is frozen and everything behind it becomes a NOP.
    assign haltFetch = (idOp == OP_HALT) || haltPending;

    always_comb begin
        idWe   = 1'b0;
        idDest = idRegC;
        case (idOp)
            OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_RELU: idWe = 1'b1;
            OP_ADDI, OP_LW: begin
                idWe   = 1'b1;
                idDest = idRegB;
            end
            default: ;
        endcase
    end

    assign exSum = exValA + exImm;

    always_comb begin
        exResult = '0;
        case (exOp)
            OP_ADD:  exResult = exValA + exValB;
            OP_SUB:  exResult = exValA - exValB;
            OP_MUL:  exResult = exValA * exValB;
            OP_MAC:  exResult = exValA * exValB + exValC;
            OP_ADDI: exResult = exSum;
            OP_LW:   exResult = dmem_rdata;
            OP_RELU: exResult = exValA[DATA_W-1] ? '0 : exValA;
            default: ;
        endcase
    end

    assign dmem_addr  = ADDR_W'(exSum);
    assign dmem_wdata = exValB;
    assign dmem_we    = (exOp == OP_SW) && !stall && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= '0;
            ifidInstr   <= NOP;
            haltPending <= 1'b0;
            exOp        <= 4'd0;
            exWe        <= 1'b0;
            exDest      <= '0;
            exValA      <= '0;
            exValB      <= '0;
            exValC      <= '0;
            exImm       <= '0;
            halted      <= 1'b0;
            CLK_cycle   <= 32'd0;
        end else begin
            if (!halted)
                CLK_cycle <= CLK_cycle + 32'd1;
            if (!stall) begin
                if (!haltFetch)
                    pc <= pc + 1'b1;
                ifidInstr <= haltFetch ? NOP : imem_data;
                if (idOp == OP_HALT)
                    haltPending <= 1'b1;
                exOp   <= idOp;
                exWe   <= idWe && (idDest != '0);
                exDest <= idDest;
                exValA <= idValA;
                exValB <= idValB;
                exValC <= idValC;
                exImm  <= idImm;
                if (exOp == OP_HALT)
                    halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (!stall && exWe) begin
            regs[exDest] <= exResult;
        end
    end

endmodule

// File: tb/tb_nn_cpu_pipe.sv
// Directed self-checking bench for nn_cpu_pipe: runs small programs from a bench-owned
// instruction ROM and data RAM and checks the logged stores and status outputs.
module tb_nn_cpu_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        halted;
    logic [31:0] CLK_cycle;

    int total = 0;
    int bad   = 0;

    logic [31:0] imem [65536];
    logic [31:0] dmem [65536];
    logic        preloadEn;
    logic [15:0] preloadAddr;
    logic [31:0] preloadData;

    int          tbCycle;
    logic [31:0] stAddr [64];
    logic [31:0] stData [64];
    int          stCyc  [64];
    int          storeCount = 0;
    int          base;

    nn_cpu_pipe #(.DATA_W(32), .ADDR_W(16), .REG_BITS(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .halted     (halted),
        .CLK_cycle  (CLK_cycle)
    );

    always #5 CLK = ~CLK;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge CLK) begin
        if (preloadEn)
            dmem[preloadAddr] <= preloadData;
        else if (dmem_we)
            dmem[dmem_addr] <= dmem_wdata;
    end

    always @(posedge CLK) begin
        if (RST)
            tbCycle <= 0;
        else
            tbCycle <= tbCycle + 1;
    end

    // Store log, sampled mid-cycle so it sees the settled strobe.
    always @(negedge CLK) begin
        if (dmem_we === 1'b1 && storeCount < 64) begin
            stAddr[storeCount] <= {16'h0000, dmem_addr};
            stData[storeCount] <= dmem_wdata;
            stCyc[storeCount]  <= tbCycle;
            storeCount         <= storeCount + 1;
        end
    end

    function automatic logic [31:0] encR(input logic [3:0] op, input logic [5:0] a,
                                         input logic [5:0] b, input logic [5:0] c);
        return {op, a, b, c, 10'd0};
    endfunction

    function automatic logic [31:0] encI(input logic [3:0] op, input logic [5:0] a,
                                         input logic [5:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    task automatic applyStimulus(input logic rstVal, input logic stallVal, input int n);
        RST   = rstVal;
        stall = stallVal;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearImem();
        for (int i = 0; i < 64; i++)
            imem[i] = 32'h0;
    endtask

    task automatic loadForwardProgram();
        clearImem();
        imem[0] = encI(4'd5, 6'd0, 6'd1, 16'd5);
        imem[1] = encI(4'd5, 6'd0, 6'd2, 16'hFFFD);
        imem[2] = encR(4'd1, 6'd1, 6'd2, 6'd3);
        imem[3] = encI(4'd7, 6'd0, 6'd3, 16'h0010);
    endtask

    initial begin
        RST         = 1'b1;
        stall       = 1'b0;
        preloadEn   = 1'b0;
        preloadAddr = 16'h0;
        preloadData = 32'h0;
        clearImem();
        @(posedge CLK);
        #1;

        $display("[TB] reset and forwarding");
        loadForwardProgram();
        base = storeCount;
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
        checkOutput("rst_halted", {31'h0, halted}, 32'h0);
        checkOutput("rst_cycle", CLK_cycle, 32'd0);
        checkOutput("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("cycle_after3", CLK_cycle, 32'd3);
        checkOutput("pc_after3", {16'h0, imem_addr}, 32'd3);
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("fwd_nstores", 32'(storeCount - base), 32'd1);
        checkOutput("fwd_addr", stAddr[base], 32'h10);
        checkOutput("fwd_data", stData[base], 32'd2);
        checkOutput("fwd_cycle", stCyc[base], 32'd5);
        checkOutput("fwd_mem", dmem[16'h0010], 32'd2);

        $display("[TB] MAC chain");
        applyStimulus(1'b1, 1'b0, 0);
        clearImem();
        imem[0] = encI(4'd5, 6'd0, 6'd4, 16'd0);
        imem[1] = encI(4'd5, 6'd0, 6'd1, 16'd5);
        imem[2] = encI(4'd5, 6'd0, 6'd2, 16'hFFFD);
        imem[3] = encR(4'd4, 6'd1, 6'd2, 6'd4);
        imem[4] = encR(4'd4, 6'd1, 6'd2, 6'd4);
        imem[5] = encR(4'd4, 6'd1, 6'd2, 6'd4);
        imem[6] = encI(4'd7, 6'd0, 6'd4, 16'h0014);
        base = storeCount;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("mac_nstores", 32'(storeCount - base), 32'd1);
        checkOutput("mac_addr", stAddr[base], 32'h14);
        checkOutput("mac_data", stData[base], 32'hFFFF_FFD3);
        checkOutput("mac_cycle", stCyc[base], 32'd8);

        $display("[TB] load-use and relu");
        applyStimulus(1'b1, 1'b0, 0);
        clearImem();
        imem[0] = encI(4'd6, 6'd0, 6'd5, 16'h0020);
        imem[1] = encR(4'd8, 6'd5, 6'd0, 6'd6);
        imem[2] = encI(4'd5, 6'd0, 6'd7, 16'd7);
        imem[3] = encR(4'd8, 6'd7, 6'd0, 6'd8);
        imem[4] = encI(4'd7, 6'd0, 6'd6, 16'h0024);
        imem[5] = encI(4'd7, 6'd0, 6'd8, 16'h0028);
        preloadEn   = 1'b1;
        preloadAddr = 16'h0020;
        preloadData = 32'hFFFF_FFF9;
        base = storeCount;
        applyStimulus(1'b1, 1'b0, 2);
        preloadEn = 1'b0;
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("lu_nstores", 32'(storeCount - base), 32'd2);
        checkOutput("lu_addr0", stAddr[base], 32'h24);
        checkOutput("lu_data0", stData[base], 32'd0);
        checkOutput("lu_cycle0", stCyc[base], 32'd6);
        checkOutput("lu_addr1", stAddr[base+1], 32'h28);
        checkOutput("lu_data1", stData[base+1], 32'd7);
        checkOutput("lu_cycle1", stCyc[base+1], 32'd7);

        $display("[TB] zero register");
        applyStimulus(1'b1, 1'b0, 0);
        clearImem();
        imem[0] = encI(4'd5, 6'd0, 6'd0, 16'd9);
        imem[1] = encI(4'd7, 6'd0, 6'd0, 16'h0030);
        base = storeCount;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("r0_nstores", 32'(storeCount - base), 32'd1);
        checkOutput("r0_addr", stAddr[base], 32'h30);
        checkOutput("r0_data", stData[base], 32'd0);
        checkOutput("r0_cycle", stCyc[base], 32'd3);

        $display("[TB] halt");
        applyStimulus(1'b1, 1'b0, 0);
        clearImem();
        imem[0] = encI(4'd5, 6'd0, 6'd1, 16'd1);
        imem[1] = encR(4'd9, 6'd0, 6'd0, 6'd0);
        imem[2] = encI(4'd5, 6'd0, 6'd1, 16'd99);
        imem[3] = encI(4'd7, 6'd0, 6'd1, 16'h0040);
        base = storeCount;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("halt_pc_c3", {16'h0, imem_addr}, 32'd2);
        checkOutput("halt_flag_c3", {31'h0, halted}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("halt_flag_c4", {31'h0, halted}, 32'd1);
        checkOutput("halt_cycle_c4", CLK_cycle, 32'd4);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("halt_pc_late", {16'h0, imem_addr}, 32'd2);
        checkOutput("halt_flag_late", {31'h0, halted}, 32'd1);
        checkOutput("halt_cycle_late", CLK_cycle, 32'd4);
        checkOutput("halt_nstores", 32'(storeCount - base), 32'd0);

        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 0);
        loadForwardProgram();
        base = storeCount;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b1, 0);
        #1;
        checkOutput("stall_we", {31'h0, dmem_we}, 32'd0);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("stall_pc_hold", {16'h0, imem_addr}, 32'd5);
        checkOutput("stall_cycle", CLK_cycle, 32'd8);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("stall_nstores", 32'(storeCount - base), 32'd1);
        checkOutput("stall_addr", stAddr[base], 32'h10);
        checkOutput("stall_data", stData[base], 32'd2);
        checkOutput("stall_st_cycle", stCyc[base], 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
